wb_bus_arbiter2: RTL and testbench
==================================

Name: wb_bus_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter that shares a single unified memory port between the core's instruction bus (M0, read-only fetch) and data bus (M1).
- Sits between the core and a single-port RAM/ROM, so both buses can address one memory.
- Grant is held for a whole transaction (request to ack); fairness is round-robin.

Parameters:
- ADR_WIDTH, 32, address width passed through to the slave.
- TIMEOUT_CYCLES, 64, cycles a granted transaction may wait for s_ack_i before abort (used only with the optional feature).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous, active-high reset
- m0_adr_i  in  ADR_WIDTH  ibus address
- m0_stb_i  in  1  ibus request
- m0_dat_o  out  32  ibus read data
- m0_ack_o  out  1  ibus ack
- m0_err_o  out  1  ibus timeout error
- m1_adr_i  in  ADR_WIDTH  dbus address
- m1_dat_i  in  32  dbus write data
- m1_dat_o  out  32  dbus read data
- m1_we_i  in  1  dbus write enable
- m1_sel_i  in  4  dbus byte select
- m1_stb_i  in  1  dbus strobe
- m1_cyc_i  in  1  dbus cycle
- m1_ack_o  out  1  dbus ack
- m1_err_o  out  1  dbus timeout error
- s_adr_o  out  ADR_WIDTH  slave address
- s_dat_o  out  32  slave write data
- s_dat_i  in  32  slave read data
- s_we_o  out  1  slave write enable
- s_sel_o  out  4  slave byte select
- s_stb_o  out  1  slave strobe
- s_cyc_o  out  1  slave cycle
- s_ack_i  in  1  slave ack

Behaviour:
- Clock and reset: one clock; wb_rst_i is asynchronous and active-high.
- Requests: req0 = m0_stb_i; req1 = m1_cyc_i & m1_stb_i.
- FSM states: IDLE, GNT0, GNT1. State and last_grant are registers.
- Reset: state=IDLE, last_grant=M1 (so M0 wins the first tie). s_stb_o, s_cyc_o, m*_ack_o and m*_err_o are 0; other outputs are don't-care but driven.
- IDLE transitions:
  - Only req0 -> GNT0. Only req1 -> GNT1.
  - Both -> grant the master that is not last_grant.
  - Arbitration latency is 1 cycle: the slave sees stb the cycle after the request.
- In GNTx: slave outputs are combinationally muxed from master x.
  - M0 forces s_we_o=0 and s_sel_o=4'hF; s_dat_o is don't-care.
  - s_stb_o = reqx; s_cyc_o = 1.
- Ack and data routing:
  - s_ack_i is routed only to the granted master's ack; the other master's ack is 0.
  - s_dat_i fans out to both m*_dat_o.
- On s_ack_i in GNTx:
  - last_grant <= x.
  - If the other master is requesting, go to GNTother the next cycle (back-to-back, no IDLE bubble). Otherwise go to IDLE.
  - Never re-grant the same master directly from an ack cycle; its stb may still be high for that cycle.
- Abort: if reqx drops in GNTx with no ack, go to IDLE with no ack generated; last_grant is unchanged.
- Simultaneous ack and new request from the same master: served after passing through IDLE, or after the other master if it is pending.
- Reset mid-transaction: immediate return to IDLE; s_stb_o=0 asynchronously.
- No combinational path from s_ack_i to s_stb_o.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on grant entry and increments each cycle in GNTx without s_ack_i.
  - When it reaches TIMEOUT_CYCLES: pulse mx_err_o for 1 cycle, drop s_stb_o/s_cyc_o that cycle, set last_grant<=x, go to IDLE.
  - A late s_ack_i arriving in IDLE is ignored.
- When undefined: no counter; m0_err_o and m1_err_o are tied 0. The ports always exist.

Decomposition:
- Shared package/header (wb_arb_defs):
  - State encodings ARB_IDLE=2'b00, ARB_GNT0=2'b01, ARB_GNT1=2'b10.
  - Master index constants M0=1'b0, M1=1'b1.
- One natural sub-module: rr_pick2, a combinational pick of the next grant from req0, req1 and last_grant. It is reusable by future N-master arbiters.

Test Plan:
- Reset then m0_stb_i=1 adr=0x100, slave acks 1 cycle after stb -> s_stb_o high 1 cycle after request; m0_ack_o pulses once; m1_ack_o stays 0.
- req0 and req1 rise the same cycle after reset -> GNT0 first; after ack, GNT1 the next cycle with no IDLE; s_adr_o switches from m0 to m1 address.
- M1 write adr=0x04000010 dat=0xCAFEF00D sel=4'b0011 -> slave sees we=1, sel=0011, matching data; only m1_ack_o asserts.
- Both masters requesting continuously for 10 transactions -> grants alternate M0,M1,M0,...; neither master is starved.
- Assert wb_rst_i mid-GNT1 (before ack) -> s_stb_o=0 immediately; after release, with no requests, state=IDLE and no ack issued.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks M1 -> m1_err_o pulses exactly 8 cycles after grant; arbiter then serves pending M0.

Source files
------------

// File: rtl/wb_arb_defs.sv
// wb_arb_defs: shared arbiter state encodings and master index constants.
package wb_arb_defs;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_t;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick; on a tie the master that was not granted last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic idx
);
  assign valid = req0 | req1;
  assign idx   = (req0 & req1) ? ~last_grant : req1;
endmodule

// File: rtl/wb_bus_arbiter2.sv
// wb_bus_arbiter2: two-master/one-slave round-robin Wishbone arbiter (ibus M0, dbus M1).
// Optional grant timeout with error pulse is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter2
  import wb_arb_defs::*;
#(
  parameter int ADR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [ADR_WIDTH-1:0] m0_adr_i,
  input  logic                 m0_stb_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic [ADR_WIDTH-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  input  logic                 m1_we_i,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_cyc_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic [ADR_WIDTH-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [31:0]          s_dat_i,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_stb_o,
  output logic                 s_cyc_o,
  input  logic                 s_ack_i
);
  arb_state_t state, state_nx;
  logic last_grant, last_nx;
  logic req0, req1, gnt0, gnt1, own_req, oth_req, pick_v, pick_i, to_hit;
  assign req0    = m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign gnt0    = state == ARB_GNT0;
  assign gnt1    = state == ARB_GNT1;
  assign own_req = gnt1 ? req1 : req0;
  assign oth_req = gnt1 ? req0 : req1;
  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .valid      (pick_v),
    .idx        (pick_i)
  );
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  // Cleared whenever the next cycle starts a new grant, so each grant waits from zero.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) cnt <= '0;
    else cnt <= (state_nx != state || state == ARB_IDLE) ? '0 : cnt + CW'(!s_ack_i);
  assign to_hit = (gnt0 | gnt1) & (cnt == TO_MAX);
`else
  assign to_hit = 1'b0;
`endif
  // An ack always leaves the granted master, so a still-high stb in the ack cycle is never re-served.
  always_comb begin
    state_nx = state;
    last_nx  = last_grant;
    if (!gnt0 && !gnt1)
      state_nx = pick_v ? (pick_i ? ARB_GNT1 : ARB_GNT0) : ARB_IDLE;
    else if (to_hit) begin
      state_nx = ARB_IDLE;
      last_nx  = gnt1;
    end else if (s_ack_i) begin
      state_nx = oth_req ? (gnt1 ? ARB_GNT0 : ARB_GNT1) : ARB_IDLE;
      last_nx  = gnt1;
    end else if (!own_req)
      state_nx = ARB_IDLE;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state      <= ARB_IDLE;
      last_grant <= M1;
    end else begin
      state      <= state_nx;
      last_grant <= last_nx;
    end
  assign s_cyc_o  = (gnt0 | gnt1) & ~to_hit;
  assign s_stb_o  = s_cyc_o & own_req;
  assign s_adr_o  = gnt1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o  = m1_dat_i;
  assign s_we_o   = gnt1 & m1_we_i;
  assign s_sel_o  = gnt1 ? m1_sel_i : 4'hF;
  assign m0_ack_o = gnt0 & s_ack_i & ~to_hit;
  assign m1_ack_o = gnt1 & s_ack_i & ~to_hit;
  assign m0_err_o = gnt0 & to_hit;
  assign m1_err_o = gnt1 & to_hit;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
endmodule

// File: tb/tb_wb_bus_arbiter2.sv
// tb_wb_bus_arbiter2: directed plus random bench for wb_bus_arbiter2 against a cycle-level bus-ownership model.
module tb_wb_bus_arbiter2;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO = 64;
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, wb_clk_i, wb_rst_i = 1'b0;
  logic [31:0] m0_adr_i = '0, m1_adr_i = '0, m1_dat_i = '0, s_dat_i = '0;
  logic m0_stb_i = 0, m1_we_i = 0, m1_stb_i = 0, m1_cyc_i = 0, s_ack_i = 0;
  logic [3:0] m1_sel_i = '0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_stb_o, s_cyc_o;
  logic [3:0] s_sel_o;
  int vectors = 0, miscompares = 0;
  int owner = -1, last = 1, waited = 0;
  int ack_seen[2];
  int ack_log[$];
  assign wb_clk_i = clk;
  always #5 clk = ~clk;
  wb_bus_arbiter2 #(.ADR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Compare this cycle's outputs with who should own the bus, then move ownership on.
  task automatic eval();
    bit req[2];
    bit to, busy, oreq;
    int nxt;
    req[0] = m0_stb_i;
    req[1] = m1_cyc_i & m1_stb_i;
    to   = TO_EN && owner >= 0 && waited == TO;
    busy = owner >= 0 && !to;
    oreq = owner >= 0 ? req[owner] : 1'b0;
    chk("cyc", 32'(s_cyc_o), 32'(busy));
    chk("stb", 32'(s_stb_o), 32'(busy && oreq));
    chk("ack0", 32'(m0_ack_o), 32'(busy && owner == 0 && s_ack_i));
    chk("ack1", 32'(m1_ack_o), 32'(busy && owner == 1 && s_ack_i));
    chk("err0", 32'(m0_err_o), 32'(to && owner == 0));
    chk("err1", 32'(m1_err_o), 32'(to && owner == 1));
    chk("dat0", m0_dat_o, s_dat_i);
    chk("dat1", m1_dat_o, s_dat_i);
    if (busy) begin
      chk("adr", s_adr_o, owner == 1 ? m1_adr_i : m0_adr_i);
      chk("we", 32'(s_we_o), owner == 1 ? 32'(m1_we_i) : 32'd0);
      chk("sel", 32'(s_sel_o), owner == 1 ? 32'(m1_sel_i) : 32'hF);
      if (owner == 1) chk("wdat", s_dat_o, m1_dat_i);
    end
    if (m0_ack_o) begin ack_seen[0]++; ack_log.push_back(0); end
    if (m1_ack_o) begin ack_seen[1]++; ack_log.push_back(1); end
    if (owner < 0)
      nxt = (req[0] && req[1]) ? 1 - last : req[0] ? 0 : req[1] ? 1 : -1;
    else if (to || s_ack_i) begin
      last = owner;
      nxt = (!to && req[1-owner]) ? 1 - owner : -1;
    end else
      nxt = oreq ? owner : -1;
    waited = (nxt == owner && owner >= 0) ? waited + 1 : 0;
    owner = nxt;
  endtask
  task automatic step(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                      input logic we, input logic [31:0] d1, input logic [3:0] sel, input logic ack);
    @(negedge clk);
    m0_stb_i = r0; m0_adr_i = a0;
    m1_stb_i = r1; m1_cyc_i = r1; m1_adr_i = a1; m1_we_i = we; m1_dat_i = d1; m1_sel_i = sel;
    s_ack_i = ack; s_dat_i = $urandom;
    #1 eval();
  endtask
  task automatic do_reset();
    @(negedge clk);
    wb_rst_i = 1'b1;
    m0_stb_i = 0; m1_stb_i = 0; m1_cyc_i = 0; s_ack_i = 0;
    @(negedge clk);
    #1;
    chk("rst_stb", 32'(s_stb_o), 0);
    chk("rst_cyc", 32'(s_cyc_o), 0);
    chk("rst_ack", 32'({m0_ack_o, m1_ack_o}), 0);
    chk("rst_err", 32'({m0_err_o, m1_err_o}), 0);
    wb_rst_i = 1'b0;
    owner = -1; last = 1; waited = 0;
  endtask
  initial begin
    bit p0, p1;
`ifdef WB_ARB_TIMEOUT_EN
    int err_at;
`endif
    do_reset();
    // single M0 fetch, slave acks one cycle after stb
    ack_seen = '{0, 0};
    step(1, 32'h100, 0, 0, 0, 0, 0, 0);
    step(1, 32'h100, 0, 0, 0, 0, 0, 1);
    step(0, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("m0_ack_once", 32'(ack_seen[0]), 1);
    chk("m1_ack_none", 32'(ack_seen[1]), 0);
    // simultaneous requests: M0 first, then M1 back-to-back
    do_reset();
    step(1, 32'h200, 1, 32'h300, 0, 0, 4'hF, 0);
    step(1, 32'h200, 1, 32'h300, 0, 0, 4'hF, 1);
    step(0, 32'h200, 1, 32'h300, 0, 0, 4'hF, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // M1 partial-word write
    ack_seen = '{0, 0};
    step(0, 0, 1, 32'h04000010, 1, 32'hCAFEF00D, 4'b0011, 0);
    step(0, 0, 1, 32'h04000010, 1, 32'hCAFEF00D, 4'b0011, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wr_m1_ack", 32'(ack_seen[1]), 1);
    chk("wr_m0_ack", 32'(ack_seen[0]), 0);
    // both masters saturating: ten transactions alternate starting with M0
    ack_seen = '{0, 0};
    ack_log.delete();
    for (int i = 0; i < 11; i++) step(1, 32'h1000 + i, 1, 32'h2000 + i, 0, 0, 4'hF, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fair_m0", 32'(ack_seen[0]), 5);
    chk("fair_m1", 32'(ack_seen[1]), 5);
    chk("fair_len", 32'(ack_log.size()), 10);
    for (int i = 0; i < ack_log.size(); i++) chk("fair_order", 32'(ack_log[i]), 32'(i % 2));
    // reset while M1 is granted and waiting
    step(0, 0, 1, 32'h500, 0, 0, 4'hF, 0);
    step(0, 0, 1, 32'h500, 0, 0, 4'hF, 0);
    @(negedge clk);
    wb_rst_i = 1'b1;
    #1;
    chk("midrst_stb", 32'(s_stb_o), 0);
    chk("midrst_cyc", 32'(s_cyc_o), 0);
    @(negedge clk);
    m1_stb_i = 0; m1_cyc_i = 0;
    wb_rst_i = 1'b0;
    owner = -1; last = 1; waited = 0;
    ack_seen = '{0, 0};
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_noack", 32'(ack_seen[0] + ack_seen[1]), 0);
`ifdef WB_ARB_TIMEOUT_EN
    // slave never acks M1: error after TO cycles, then pending M0 is served
    do_reset();
    err_at = -1;
    step(0, 0, 1, 32'h600, 0, 0, 4'hF, 0);
    for (int i = 0; i <= TO; i++) begin
      step(i > 0, 32'h700, 1, 32'h600, 0, 0, 4'hF, 0);
      if (m1_err_o && err_at < 0) err_at = i;
    end
    chk("to_err_at", 32'(err_at), 32'(TO));
    ack_seen = '{0, 0};
    step(1, 32'h700, 0, 0, 0, 0, 0, 0);
    step(1, 32'h700, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_m0_served", 32'(ack_seen[0]), 1);
`endif
    // random traffic: masters hold stb until ack/err, occasionally abort; slave acks at random
    p0 = 0; p1 = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (p0 && $urandom_range(19) == 0) p0 = 0;
      else if (!p0 && $urandom_range(1) == 1) begin p0 = 1; m0_adr_i = $urandom; end
      if (p1 && $urandom_range(19) == 0) p1 = 0;
      else if (!p1 && $urandom_range(1) == 1) begin
        p1 = 1; m1_adr_i = $urandom; m1_dat_i = $urandom; m1_we_i = 1'($urandom); m1_sel_i = 4'($urandom);
      end
      m0_stb_i = p0;
      m1_stb_i = p1;
      m1_cyc_i = p1 | ($urandom_range(3) == 0);
      s_ack_i = $urandom_range(2) == 0;
      s_dat_i = $urandom;
      #1 eval();
      if (m0_ack_o || m0_err_o) p0 = 0;
      if (m1_ack_o || m1_err_o) p1 = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
